stream_serializer: RTL and testbench
====================================

# stream_serializer

Width-reducing valid/ready stage that sits directly downstream of a `pipeline` instance. It accepts one wide word of `NUM_BEATS` lanes per handshake and emits its lanes one per beat, lowest lane first. A per-word length field shortens the burst. The last beat of a word and the acceptance of the next word share one cycle, so back-to-back words stream without bubbles.

## Interface
- `DATA_WIDTH`, 8, width of one output beat (lane).
- `NUM_BEATS`, 4, lanes per input word; legal range ≥ 2.
- `LEN_WIDTH`, `$clog2(NUM_BEATS)`, derived; width of the length field.
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk_i`  input  1  rising-edge clock.
- `arst_n`  input  1  asynchronous active-low reset.
- `data_in`  input  `NUM_BEATS*DATA_WIDTH`  wide word; lane k = `data_in[k*DATA_WIDTH +: DATA_WIDTH]`.
- `data_in_len`  input  `LEN_WIDTH`  beats to emit minus one; a value of L means L+1 beats (lanes 0..L).
- `data_in_valid`  input  1  upstream word valid.
- `data_in_ready`  output  1  serializer can take a word this cycle.
- `data_out`  output  `DATA_WIDTH`  current beat.
- `data_out_valid`  output  1  beat valid.
- `data_out_ready`  input  1  downstream accepts beat.
- `data_out_last`  output  1  final beat of the word; present only with `STREAM_SERIALIZER_LAST_EN`.

## Operation
- **State.** A word register, a beat counter `cnt` and a last-index register `len_q` (all `LEN_WIDTH` wide), and a `busy` flag.
- **IDLE (`busy` = 0).**
  - `data_in_ready` = 1 and `data_out_valid` = 0.
  - An input handshake loads the word and `len_q`, clears `cnt` to 0 and sets `busy`.
- **SERIAL (`busy` = 1).**
  - `data_out_valid` = 1 and `data_out` = lane `cnt` of the word register.
  - A handshake with `cnt` != `len_q` increments `cnt`.
  - A handshake with `cnt` == `len_q` ends the word:
    - If `data_in_valid` is also 1, the new word loads, `cnt` returns to 0 and `busy` stays 1.
    - Otherwise `busy` clears.
- **Ready rule.** `data_in_ready` = !`busy` || (`data_out_ready` && `cnt` == `len_q`). This is a combinational path from `data_out_ready`; downstream must not make `data_out_ready` depend on `data_in_ready`.
- **Length clamp.** A `data_in_len` value > `NUM_BEATS-1` (possible when `NUM_BEATS` is not a power of 2) is clamped to `NUM_BEATS-1` at load.
- **Stable outputs.** While `data_out_valid` = 1 and `data_out_ready` = 0, `data_out` (and `data_out_last` when present) hold stable.
- **Lanes past the length.** Lanes above `len_q` are never emitted.
- **Reset.** Asynchronous, any time including mid-word.
  - `busy` = 0, `cnt` = 0, `len_q` = 0, word register = 0.
  - Outputs: `data_out_valid` = 0, `data_in_ready` = 1, `data_out` = 0, `data_out_last` = 0.
  - The partial word is discarded.

## Timing
- **Latency.** Word accepted at edge N; its lane 0 is valid after edge N and is consumable at edge N+1.
- **Throughput.**
  - A word of L+1 beats occupies exactly L+1 output cycles when `data_out_ready` = 1 throughout.
  - There is zero idle cycle between consecutive words.
- **Single-beat words** (`data_in_len` = 0) stream at one word per cycle.
- **Backpressure.** With `data_out_ready` = 0, `cnt` and the register contents freeze indefinitely.

## Configuration
- **Macro `STREAM_SERIALIZER_LAST_EN`.**
- **Defined.** The `data_out_last` port exists and equals `busy` && `cnt` == `len_q`; it is 0 out of reset.
- **Undefined.** The port and its logic are absent; all other behaviour is identical.

## Test plan
Benches use `DATA_WIDTH`=8, `NUM_BEATS`=4.
- **Full word.** Word 0x44332211, len 3, `data_out_ready` held at 1 -> beats 0x11, 0x22, 0x33, 0x44 on four consecutive cycles; last asserted only with 0x44; `data_in_ready` = 0 during the first three beats.
- **Back-to-back words.** 0x44332211 (len 3) then 0x88776655 (len 1), `data_in_valid` held at 1 -> beats 0x11, 0x22, 0x33, 0x44, 0x55, 0x66 with no gap; the second word is accepted in the same cycle 0x44 is consumed.
- **Backpressure.** Word 0xDDCCBBAA, len 3; drop `data_out_ready` for 3 cycles while 0xBB is presented -> 0xBB holds stable and valid, then 0xCC and 0xDD follow; no beat is lost or duplicated.
- **Single-beat stream.** Five words, each with len 0 and lane 0 = 0x01..0x05, continuous handshakes -> five beats 0x01..0x05 in five cycles, last = 1 on each.
- **Reset mid-word.** Deassert `arst_n` after beat 0x22 of 0x44332211 -> `data_out_valid` falls to 0 immediately and `data_in_ready` = 1; after release, word 0x000000EE with len 0 yields a single beat 0xEE.
- **Length clamp.** Ask whether the clamp is reachable in this configuration: it is not with `NUM_BEATS`=4, so rerun with `NUM_BEATS`=3, word 0x332211, len 3 -> beats 0x11, 0x22, 0x33 only.

Source files
------------

// File: rtl/stream_serializer.sv
// Wide-to-narrow valid/ready serializer: one NUM_BEATS-lane word in, lanes out lowest first.
// Optional data_out_last port is enabled by defining STREAM_SERIALIZER_LAST_EN.
module stream_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_BEATS  = 4,
  parameter int LEN_WIDTH  = $clog2(NUM_BEATS)
) (
  input  logic                            clk_i,
  input  logic                            arst_n,
  input  logic [NUM_BEATS*DATA_WIDTH-1:0] data_in,
  input  logic [LEN_WIDTH-1:0]            data_in_len,
  input  logic                            data_in_valid,
  output logic                            data_in_ready,
  output logic [DATA_WIDTH-1:0]           data_out,
  output logic                            data_out_valid,
  input  logic                            data_out_ready
`ifdef STREAM_SERIALIZER_LAST_EN
  ,
  output logic                            data_out_last
`endif
);

  localparam logic [LEN_WIDTH-1:0] MAX_IDX = LEN_WIDTH'(NUM_BEATS - 1);

  logic [NUM_BEATS-1:0][DATA_WIDTH-1:0] word_q;
  logic [LEN_WIDTH-1:0]                 cnt;
  logic [LEN_WIDTH-1:0]                 len_q;
  logic                                 busy;

  logic                 at_last;
  logic                 load;
  logic                 beat_hs;
  logic [LEN_WIDTH-1:0] len_clamped;

  assign at_last = busy && (cnt == len_q);
  assign beat_hs = busy && data_out_ready;

  // Ready looks through to data_out_ready so the next word can load on the final beat.
  assign data_in_ready = !busy || (data_out_ready && (cnt == len_q));
  assign load          = data_in_valid && data_in_ready;

  // Only reachable when NUM_BEATS is not a power of two.
  assign len_clamped = (data_in_len > MAX_IDX) ? MAX_IDX : data_in_len;

  always_ff @(posedge clk_i or negedge arst_n) begin
    if (!arst_n) begin
      word_q <= '0;
      cnt    <= '0;
      len_q  <= '0;
      busy   <= 1'b0;
    end else if (load) begin
      word_q <= data_in;
      len_q  <= len_clamped;
      cnt    <= '0;
      busy   <= 1'b1;
    end else if (beat_hs) begin
      if (cnt == len_q) busy <= 1'b0;
      else              cnt  <= cnt + LEN_WIDTH'(1);
    end
  end

  assign data_out_valid = busy;
  assign data_out       = busy ? word_q[cnt] : '0;

`ifdef STREAM_SERIALIZER_LAST_EN
  assign data_out_last = at_last;
`else
  logic unused_at_last;
  assign unused_at_last = at_last;
`endif

endmodule

// File: tb/tb_stream_serializer.sv
// Self-checking bench for stream_serializer: directed scenarios plus random traffic
// against a beat-queue reference model; a second NUM_BEATS=3 instance covers the length clamp.
module tb_stream_serializer;

  logic        clk_i = 1'b0;
  logic        arst_n;
  logic [31:0] data_in;
  logic [1:0]  data_in_len;
  logic        data_in_valid;
  logic        data_in_ready;
  logic [7:0]  data_out;
  logic        data_out_valid;
  logic        data_out_ready;
`ifdef STREAM_SERIALIZER_LAST_EN
  logic        data_out_last;
`endif

  logic [23:0] d3_in;
  logic [1:0]  d3_len;
  logic        d3_in_valid;
  logic        d3_in_ready;
  logic [7:0]  d3_out;
  logic        d3_out_valid;
  logic        d3_out_ready;
`ifdef STREAM_SERIALIZER_LAST_EN
  logic        d3_out_last;
`endif

  always #5 clk_i = ~clk_i;

  stream_serializer #(.DATA_WIDTH(8), .NUM_BEATS(4)) dut (
    .clk_i(clk_i), .arst_n(arst_n),
    .data_in(data_in), .data_in_len(data_in_len),
    .data_in_valid(data_in_valid), .data_in_ready(data_in_ready),
    .data_out(data_out), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
`ifdef STREAM_SERIALIZER_LAST_EN
    , .data_out_last(data_out_last)
`endif
  );

  stream_serializer #(.DATA_WIDTH(8), .NUM_BEATS(3)) dut3 (
    .clk_i(clk_i), .arst_n(arst_n),
    .data_in(d3_in), .data_in_len(d3_len),
    .data_in_valid(d3_in_valid), .data_in_ready(d3_in_ready),
    .data_out(d3_out), .data_out_valid(d3_out_valid),
    .data_out_ready(d3_out_ready)
`ifdef STREAM_SERIALIZER_LAST_EN
    , .data_out_last(d3_out_last)
`endif
  );

  int total = 0;
  int bad   = 0;

  // Reference model: the beats still owed downstream, oldest first.
  logic [7:0] q[$];
  logic       acc;
  int         emitted;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs are already driven (after a negedge); check, update the model, advance one cycle.
  task automatic step();
    logic exp_ready;
    logic exp_valid;
    int   nb;
    #1;
    exp_valid = (q.size() != 0);
    exp_ready = (q.size() == 0) || (data_out_ready && q.size() == 1);
    chk("out_valid", {31'd0, data_out_valid}, {31'd0, exp_valid});
    chk("in_ready", {31'd0, data_in_ready}, {31'd0, exp_ready});
    if (exp_valid) chk("data_out", {24'd0, data_out}, {24'd0, q[0]});
`ifdef STREAM_SERIALIZER_LAST_EN
    chk("last", {31'd0, data_out_last}, {31'd0, (q.size() == 1)});
`endif
    if (exp_valid && data_out_ready) begin
      void'(q.pop_front());
      emitted++;
    end
    acc = data_in_valid && exp_ready;
    if (acc) begin
      nb = int'(data_in_len) + 1;
      for (int k = 0; k < nb; k++) q.push_back(data_in[k*8 +: 8]);
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Present a word and hold it until the model says it was accepted.
  task automatic send(input logic [31:0] w, input logic [1:0] len);
    int n;
    data_in = w; data_in_len = len; data_in_valid = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 40) begin step(); n++; end
    if (!acc) chk("send_timeout", 32'd1, 32'd0);
    data_in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    data_out_ready = 1'b1;
    while (q.size() != 0 && n < 40) begin step(); n++; end
    chk("drain_empty", q.size(), 32'd0);
    step();
  endtask

  initial begin
    arst_n = 1'b0;
    data_in = '0; data_in_len = '0; data_in_valid = 1'b0; data_out_ready = 1'b0;
    d3_in = '0; d3_len = '0; d3_in_valid = 1'b0; d3_out_ready = 1'b0;
    emitted = 0;
    #12;
    chk("rst_valid", {31'd0, data_out_valid}, 32'd0);
    chk("rst_ready", {31'd0, data_in_ready}, 32'd1);
    chk("rst_data", {24'd0, data_out}, 32'd0);
`ifdef STREAM_SERIALIZER_LAST_EN
    chk("rst_last", {31'd0, data_out_last}, 32'd0);
`endif
    @(negedge clk_i);
    arst_n = 1'b1;
    @(negedge clk_i);

    // Full word, ready held high
    data_out_ready = 1'b1;
    send(32'h44332211, 2'd3);
    chk("full_first", {24'd0, data_out}, 32'h11);
    emitted = 0;
    drain();
    chk("full_count", emitted, 32'd4);

    // Back-to-back words, valid held
    emitted = 0;
    send(32'h44332211, 2'd3);
    send(32'h88776655, 2'd1);
    chk("b2b_no_gap", emitted, 32'd4);
    drain();
    chk("b2b_count", emitted, 32'd6);

    // Backpressure while 0xBB is presented
    send(32'hDDCCBBAA, 2'd3);
    step();
    data_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold", {24'd0, data_out}, 32'hBB);
      step();
    end
    drain();

    // Single-beat words at one per cycle
    emitted = 0;
    for (int i = 1; i <= 5; i++) send({24'd0, 8'(i)}, 2'd0);
    drain();
    chk("single_count", emitted, 32'd5);

    // Reset mid-word
    send(32'h44332211, 2'd3);
    step();
    step();
    arst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, data_out_valid}, 32'd0);
    chk("mid_rst_ready", {31'd0, data_in_ready}, 32'd1);
    q.delete();
    @(negedge clk_i);
    arst_n = 1'b1;
    emitted = 0;
    send(32'h000000EE, 2'd0);
    chk("post_rst_beat", {24'd0, data_out}, 32'hEE);
    drain();
    chk("post_rst_count", emitted, 32'd1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      data_in        = $urandom;
      data_in_len    = 2'($urandom_range(0, 3));
      data_in_valid  = ($urandom_range(0, 3) != 0);
      data_out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    data_in_valid = 1'b0;
    drain();

    // Length clamp on the three-lane instance
    d3_in = 24'h332211; d3_len = 2'd3; d3_in_valid = 1'b1; d3_out_ready = 1'b1;
    #1;
    chk("clamp_ready", {31'd0, d3_in_ready}, 32'd1);
    @(negedge clk_i);
    d3_in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      logic [7:0] exp_b;
      exp_b = 8'(8'h11 * (i + 1));
      chk("clamp_valid", {31'd0, d3_out_valid}, 32'd1);
      chk("clamp_beat", {24'd0, d3_out}, {24'd0, exp_b});
`ifdef STREAM_SERIALIZER_LAST_EN
      chk("clamp_last", {31'd0, d3_out_last}, {31'd0, (i == 2)});
`endif
      @(negedge clk_i);
    end
    chk("clamp_done", {31'd0, d3_out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
